sub_shift_rows: RTL and testbench

- Iterative AES SubBytes + ShiftRows stage, directly upstream of the MixColumns combinational block.
- Accepts a 4x4 byte state over a valid/ready handshake.
- Substitutes LANES bytes per cycle through forward AES S-boxes, applies ShiftRows, and holds the result until the consumer accepts it.
- Trades latency for S-box area inside the round datapath.

---
 rtl/sub_shift_rows.sv | 113 +++++++++++
 tb/tb_sub_shift_rows.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: LANES bytes per cycle through S-boxes,
// then the ShiftRows permutation is folded into the output register load.

module sub_shift_rows_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[din];
endmodule

module sub_shift_rows #(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:3][0:3][7:0]   state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:3][0:3][7:0]   state_out
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t                    st;
    logic [CW-1:0]           cnt;
    logic [15:0][7:0]        work;      // linear byte index k = col*4 + row
    logic [15:0][7:0]        work_nxt;
    logic [3:0]              base;
    logic [LANES-1:0][7:0]   lane_out;

    // LANES=16 truncates to 0 here, but then cnt is always 0 as well
    assign base = 4'(LANES) * 4'(cnt);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sub_shift_rows_sbox u_sbox (
            .din  (work[base + 4'(g)]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        work_nxt = work;
        for (int i = 0; i < LANES; i++)
            work_nxt[base + 4'(i)] = lane_out[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state_out <= '0;
            work      <= '0;
            cnt       <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        for (int r = 0; r < 4; r++)
                            for (int c = 0; c < 4; c++)
                                work[4'(c * 4 + r)] <= state_in[2'(r)][2'(c)];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        st       <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        // ShiftRows: row r rotates left by r
                        for (int r = 0; r < 4; r++)
                            for (int c = 0; c < 4; c++)
                                state_out[2'(r)][2'(c)] <= work_nxt[4'(((c + r) % 4) * 4 + r)];
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_shift_rows.sv
// Bench for sub_shift_rows: one instance per legal LANES value, S-box reference
// derived from GF(2^8) inversion plus the affine map.

module tb_sub_shift_rows;
    typedef logic [0:3][0:3][7:0] st_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid  [5];
    logic in_ready  [5];
    logic out_valid [5];
    logic out_ready [5];
    st_t  st_in     [5];
    st_t  st_out    [5];

    int tests = 0;
    int fails = 0;
    logic [7:0] sref [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_shift_rows #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (st_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (st_out[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic st_t model(input st_t s);
        st_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = sref[s[r][(c + r) % 4]];
        return m;
    endfunction

    // column-major hex literal: first byte is row0/col0, then row1/col0, ...
    function automatic st_t mk(input logic [127:0] v);
        st_t m;
        for (int k = 0; k < 16; k++)
            m[k % 4][k / 4] = v[127 - 8 * k -: 8];
        return m;
    endfunction

    function automatic st_t rnd();
        st_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 8'($urandom);
        return m;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d: accept, latency, result, drain.
    task automatic run_one(input int d, input st_t s, input st_t exp, output st_t got);
        int n = 0;
        int lat = 0;
        @(negedge clk);
        st_in[d] = s;
        in_valid[d] = 1'b1;
        out_ready[d] = 1'b0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk($sformatf("latency_L%0d", 1 << d), 128'(lat), 128'(16 >> d));
        chk($sformatf("data_L%0d", 1 << d), st_out[d], exp);
        got = st_out[d];
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        chk($sformatf("drain_valid_L%0d", 1 << d), 128'(out_valid[d]), 128'(0));
        chk($sformatf("drain_ready_L%0d", 1 << d), 128'(in_ready[d]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t appb_in, appb_out, got, s, s2;
        st_t q[3];
        int acc_cyc[3];
        int ai, oi, cyc, n;
        logic [7:0] a0, a1, a2, a3;

        for (int i = 0; i < 256; i++) sref[i] = sbox_calc(8'(i));
        for (int d = 0; d < 5; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            st_in[d] = '0;
        end

        #2 rst = 1'b1;
        #1;
        chk("reset_in_ready", 128'(in_ready[2]), 128'(1));
        chk("reset_out_valid", 128'(out_valid[2]), 128'(0));
        chk("reset_state_out", st_out[2], 128'(0));
        @(negedge clk) rst = 1'b0;

        // FIPS-197 App. B round 1 on every LANES value
        appb_in  = mk(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        appb_out = mk(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        for (int d = 0; d < 5; d++) begin
            run_one(d, appb_in, appb_out, got);
            if (d == 2) begin
                a0 = got[0][0]; a1 = got[1][0]; a2 = got[2][0]; a3 = got[3][0];
                chk("mixcol_col0",
                    128'({xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                          a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                          xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)}),
                    128'h046681e5);
            end
        end

        run_one(2, '0, {16{8'h63}}, got);
        run_one(2, {16{8'h53}}, {16{8'hed}}, got);

        for (int d = 0; d < 5; d++)
            for (int j = 0; j < 3; j++) begin
                s = rnd();
                run_one(d, s, model(s), got);
            end

        // Backpressure with an ignored in_valid pulse during DONE
        s = rnd();
        s2 = rnd();
        @(negedge clk);
        st_in[2] = s;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid[2] && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid[2]), 128'(1));
            chk("bp_in_ready", 128'(in_ready[2]), 128'(0));
            chk("bp_data", st_out[2], model(s));
            if (i == 3) begin
                st_in[2] = s2;
                in_valid[2] = 1'b1;
            end else begin
                in_valid[2] = 1'b0;
            end
        end
        @(negedge clk) out_ready[2] = 1'b1;
        @(posedge clk);
        #1 out_ready[2] = 1'b0;
        chk("bp_release_valid", 128'(out_valid[2]), 128'(0));
        chk("bp_release_ready", 128'(in_ready[2]), 128'(1));
        repeat (3) @(posedge clk);
        #1 chk("bp_pulse_ignored", 128'(in_ready[2]), 128'(1));

        // Asynchronous reset two cycles into BUSY
        s = rnd();
        @(negedge clk);
        st_in[2] = s;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_out_valid", 128'(out_valid[2]), 128'(0));
        chk("rst_busy_in_ready", 128'(in_ready[2]), 128'(1));
        chk("rst_busy_state_out", st_out[2], 128'(0));
        @(negedge clk) rst = 1'b0;
        s = rnd();
        run_one(2, s, model(s), got);

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 3; i++) q[i] = rnd();
        ai = 0; oi = 0; cyc = 0;
        out_ready[2] = 1'b1;
        while (oi < 3 && cyc < 100) begin
            @(negedge clk);
            if (out_valid[2]) begin
                chk($sformatf("b2b_data%0d", oi), st_out[2], model(q[oi]));
                oi++;
            end
            if (ai < 3) begin
                st_in[2] = q[ai];
                in_valid[2] = 1'b1;
                if (in_ready[2]) begin
                    acc_cyc[ai] = cyc;
                    ai++;
                end
            end else begin
                in_valid[2] = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b0;
        chk("b2b_count", 128'(oi), 128'(3));
        chk("b2b_spacing01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
        chk("b2b_spacing12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(6));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
